// File: rtl/alu_sequencer_pkg.sv
// Shared encodings for the ALU sequencer: opcodes, 74181 and shifter control
// words, FSM states and the decoded-operation record.
package alu_sequencer_pkg;

    // Request opcodes
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADC  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_SBC  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_CMP  = 4'h8;
    localparam logic [3:0] OP_SHL  = 4'h9;
    localparam logic [3:0] OP_SHR  = 4'hA;
    localparam logic [3:0] OP_SHLN = 4'hB;
    localparam logic [3:0] OP_SHRN = 4'hC;
    localparam logic [3:0] OP_MUL  = 4'hD;

    // 74181 control words {S3..S0, M}
    localparam logic [4:0] F_ADD   = 5'b10010;  // A plus B plus cin
    localparam logic [4:0] F_SUB   = 5'b01100;  // A minus B minus 1 plus cin
    localparam logic [4:0] F_AND   = 5'b10111;
    localparam logic [4:0] F_OR    = 5'b11101;
    localparam logic [4:0] F_XOR   = 5'b01101;
    localparam logic [4:0] F_NOTA  = 5'b00001;
    localparam logic [4:0] F_PASSA = 5'b11111;

    // Shifter control words (upper two bits are don't-care, driven 0)
    localparam logic [4:0] F_SHL   = 5'b00101;
    localparam logic [4:0] F_SHR   = 5'b00010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_SHIFT_LOOP,
        ST_MUL_ADD,
        ST_MUL_SHIFT,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        CLS_SINGLE,
        CLS_SHIFTN,
        CLS_MUL,
        CLS_ILLEGAL
    } op_class_t;

    typedef struct packed {
        logic [4:0] f;
        logic       csel;
        logic       ucin;
        logic       not_alu_oe;
        logic       not_shift_oe;
        logic       upd_c;
        logic       upd_z;
        logic       zero_result;   // response carries 0 instead of the bus value
        op_class_t  cls;
    } op_dec_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response handshake plus the ALU datapath pins of the sequencer.
//
// Handshake: a request transfers on a rising clock edge where req_valid and
// req_ready are both high; req_ready is high only while the sequencer is
// idle, so a request held during a busy period is simply not taken.
// rsp_valid is a single-cycle pulse with no back-pressure; rsp_result and
// the flags stay stable until the next pulse.
interface alu_sequencer_if #(
    parameter int CNT_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_op;
    logic [15:0]      req_a;
    logic [15:0]      req_b;
    logic [CNT_W-1:0] req_count;

    logic             rsp_valid;
    logic [15:0]      rsp_result;
    logic             carry_flag;
    logic             zero_flag;

    logic [15:0]      alu_a;
    logic [15:0]      alu_b;
    logic [4:0]       alu_f;
    logic             alu_csel;
    logic             alu_ucin;
    logic             alu_srcin;
    logic             alu_notALUOE;
    logic             alu_notShiftOE;
    logic [15:0]      alu_y;
    logic             alu_cout;
    logic             alu_zout;

    modport master (
        input  req_valid, req_op, req_a, req_b, req_count,
        input  alu_y, alu_cout, alu_zout,
        output req_ready, rsp_valid, rsp_result, carry_flag, zero_flag,
        output alu_a, alu_b, alu_f, alu_csel, alu_ucin, alu_srcin,
        output alu_notALUOE, alu_notShiftOE
    );

    modport slave (
        output req_valid, req_op, req_a, req_b, req_count,
        output alu_y, alu_cout, alu_zout,
        input  req_ready, rsp_valid, rsp_result, carry_flag, zero_flag,
        input  alu_a, alu_b, alu_f, alu_csel, alu_ucin, alu_srcin,
        input  alu_notALUOE, alu_notShiftOE
    );
endinterface

// File: rtl/alu_sequencer_op_decode.sv
// Combinational opcode decoder: ALU control word, carry-in source, which
// output enable to pull low, which flags to update and the sequencing class.
module alu_sequencer_op_decode
    import alu_sequencer_pkg::*;
#(
    parameter bit MUL_EN = 1'b1
) (
    input  logic [3:0] op,
    output op_dec_t    dec
);

    // Map opcode to its control record; unknown opcodes fall to the illegal class
    always_comb begin
        dec.f            = 5'b00000;
        dec.csel         = 1'b0;
        dec.ucin         = 1'b0;
        dec.not_alu_oe   = 1'b1;
        dec.not_shift_oe = 1'b1;
        dec.upd_c        = 1'b0;
        dec.upd_z        = 1'b0;
        dec.zero_result  = 1'b0;
        dec.cls          = CLS_SINGLE;
        case (op)
            OP_ADD: begin
                dec.f = F_ADD; dec.not_alu_oe = 1'b0;
                dec.upd_c = 1'b1; dec.upd_z = 1'b1;
            end
            OP_ADC: begin
                dec.f = F_ADD; dec.csel = 1'b1; dec.not_alu_oe = 1'b0;
                dec.upd_c = 1'b1; dec.upd_z = 1'b1;
            end
            OP_SUB: begin
                dec.f = F_SUB; dec.ucin = 1'b1; dec.not_alu_oe = 1'b0;
                dec.upd_c = 1'b1; dec.upd_z = 1'b1;
            end
            OP_SBC: begin
                dec.f = F_SUB; dec.csel = 1'b1; dec.not_alu_oe = 1'b0;
                dec.upd_c = 1'b1; dec.upd_z = 1'b1;
            end
            OP_AND: begin
                dec.f = F_AND; dec.not_alu_oe = 1'b0; dec.upd_z = 1'b1;
            end
            OP_OR: begin
                dec.f = F_OR; dec.not_alu_oe = 1'b0; dec.upd_z = 1'b1;
            end
            OP_XOR: begin
                dec.f = F_XOR; dec.not_alu_oe = 1'b0; dec.upd_z = 1'b1;
            end
            OP_NOT: begin
                dec.f = F_NOTA; dec.not_alu_oe = 1'b0; dec.upd_z = 1'b1;
            end
            OP_CMP: begin
                dec.f = F_SUB; dec.ucin = 1'b1; dec.not_alu_oe = 1'b0;
                dec.upd_c = 1'b1; dec.upd_z = 1'b1; dec.zero_result = 1'b1;
            end
            OP_SHL: begin
                dec.f = F_SHL; dec.not_shift_oe = 1'b0;
                dec.upd_c = 1'b1; dec.upd_z = 1'b1;
            end
            OP_SHR: begin
                dec.f = F_SHR; dec.not_shift_oe = 1'b0;
                dec.upd_c = 1'b1; dec.upd_z = 1'b1;
            end
            OP_SHLN: begin
                dec.f = F_SHL; dec.not_shift_oe = 1'b0;
                dec.upd_c = 1'b1; dec.upd_z = 1'b1; dec.cls = CLS_SHIFTN;
            end
            OP_SHRN: begin
                dec.f = F_SHR; dec.not_shift_oe = 1'b0;
                dec.upd_c = 1'b1; dec.upd_z = 1'b1; dec.cls = CLS_SHIFTN;
            end
            OP_MUL: begin
                if (MUL_EN) begin
                    dec.f = F_ADD; dec.not_alu_oe = 1'b0;
                    dec.upd_c = 1'b1; dec.upd_z = 1'b1; dec.cls = CLS_MUL;
                end else begin
                    dec.zero_result = 1'b1; dec.cls = CLS_ILLEGAL;
                end
            end
            default: begin
                dec.zero_result = 1'b1;
                dec.cls         = CLS_ILLEGAL;
            end
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Control-side master of the 16-bit 74181/shifter datapath. Takes one
// request at a time, drives the ALU pins, captures the bus result and keeps
// the carry/zero flags; multi-bit shifts and multiply are sequenced here.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter bit MUL_EN = 1'b1,
    parameter int CNT_W  = 4
) (
    input  logic            clock,
    input  logic            reset,
    alu_sequencer_if.master bus,
    output state_t          dbg_state
);

    // Counter must hold both a shift count and the 16 multiply iterations
    localparam int CW = (CNT_W > 4) ? CNT_W : 4;

    state_t        state_q, state_d;
    logic [3:0]    op_q, op_d;
    logic [15:0]   a_q, a_d;          // operand A / shift word / product accumulator
    logic [15:0]   b_q, b_d;          // operand B / multiplicand
    logic [15:0]   mp_q, mp_d;        // multiplier, consumed LSB first
    logic [15:0]   result_q, result_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic          zero_q, zero_d;

    logic [3:0]    dec_op;
    op_dec_t       dec;

    // While idle the incoming opcode is decoded to pick the sequencing class
    assign dec_op = (state_q == ST_IDLE) ? bus.req_op : op_q;

    alu_sequencer_op_decode #(.MUL_EN(MUL_EN)) u_decode (
        .op  (dec_op),
        .dec (dec)
    );

    assign bus.alu_srcin  = carry_q;
    assign bus.rsp_result = result_q;
    assign bus.carry_flag = carry_q;
    assign bus.zero_flag  = zero_q;
    assign dbg_state      = state_q;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= 4'h0;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            mp_q     <= 16'h0000;
            result_q <= 16'h0000;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mp_q     <= mp_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

    // ALU pin and handshake drive, purely from registered state (both OEs high outside execute)
    always_comb begin
        bus.req_ready      = 1'b0;
        bus.rsp_valid      = 1'b0;
        bus.alu_a          = 16'h0000;
        bus.alu_b          = 16'h0000;
        bus.alu_f          = 5'b00000;
        bus.alu_csel       = 1'b0;
        bus.alu_ucin       = 1'b0;
        bus.alu_notALUOE   = 1'b1;
        bus.alu_notShiftOE = 1'b1;
        case (state_q)
            ST_IDLE: bus.req_ready = 1'b1;
            ST_EXEC: begin
                bus.alu_a          = a_q;
                bus.alu_b          = b_q;
                bus.alu_f          = dec.f;
                bus.alu_csel       = dec.csel;
                bus.alu_ucin       = dec.ucin;
                bus.alu_notALUOE   = dec.not_alu_oe;
                bus.alu_notShiftOE = dec.not_shift_oe;
            end
            ST_SHIFT_LOOP: begin
                bus.alu_a = a_q;
                if (cnt_q == '0) begin
                    // Zero count: one pass-A cycle so Z reflects the operand
                    bus.alu_f        = F_PASSA;
                    bus.alu_notALUOE = 1'b0;
                end else begin
                    bus.alu_f          = dec.f;
                    bus.alu_csel       = dec.csel;
                    bus.alu_ucin       = dec.ucin;
                    bus.alu_notShiftOE = 1'b0;
                end
            end
            ST_MUL_ADD: begin
                bus.alu_a        = a_q;
                bus.alu_b        = b_q;
                bus.alu_f        = F_ADD;
                bus.alu_notALUOE = 1'b0;
            end
            ST_MUL_SHIFT: begin
                bus.alu_a          = b_q;
                bus.alu_f          = F_SHL;
                bus.alu_notShiftOE = 1'b0;
            end
            ST_DONE: bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Next-state, working-register and flag updates; bus captured at the end of each execute cycle
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        mp_d     = mp_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    op_d = bus.req_op;
                    case (dec.cls)
                        CLS_SHIFTN: begin
                            a_d     = bus.req_a;
                            cnt_d   = CW'(bus.req_count);
                            state_d = ST_SHIFT_LOOP;
                        end
                        CLS_MUL: begin
                            a_d     = 16'h0000;
                            b_d     = bus.req_a;
                            mp_d    = bus.req_b;
                            cnt_d   = CW'(15);
                            state_d = ST_MUL_ADD;
                        end
                        default: begin
                            a_d     = bus.req_a;
                            b_d     = bus.req_b;
                            state_d = ST_EXEC;
                        end
                    endcase
                end
            end
            ST_EXEC: begin
                result_d = dec.zero_result ? 16'h0000 : bus.alu_y;
                if (dec.upd_c) carry_d = bus.alu_cout;
                if (dec.upd_z) zero_d  = bus.alu_zout;
                state_d = ST_DONE;
            end
            ST_SHIFT_LOOP: begin
                if (cnt_q == '0) begin
                    result_d = bus.alu_y;
                    zero_d   = bus.alu_zout;
                    state_d  = ST_DONE;
                end else begin
                    a_d     = bus.alu_y;
                    carry_d = bus.alu_cout;
                    zero_d  = bus.alu_zout;
                    if (cnt_q == CW'(1)) begin
                        result_d = bus.alu_y;
                        state_d  = ST_DONE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            ST_MUL_ADD: begin
                if (mp_q[0]) a_d = bus.alu_y;
                state_d = ST_MUL_SHIFT;
            end
            ST_MUL_SHIFT: begin
                b_d  = bus.alu_y;
                mp_d = {1'b0, mp_q[15:1]};
                if (cnt_q == '0) begin
                    result_d = a_q;
                    carry_d  = 1'b0;
                    zero_d   = (a_q == 16'h0000);
                    state_d  = ST_DONE;
                end else begin
                    cnt_d   = cnt_q - CW'(1);
                    state_d = ST_MUL_ADD;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 74181/shifter model
// hanging off the alu_* pins.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    logic   clk;
    logic   rst;
    state_t dbg_state;
    int     checks;
    int     failures;

    alu_sequencer_if #(.CNT_W(4)) bus ();

    alu_sequencer #(.MUL_EN(1'b1), .CNT_W(4)) dut (
        .clock     (clk),
        .reset     (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model: 74181 when notALUOE low, shifter when notShiftOE low
    logic        m_cin;
    logic        m_co;
    logic [15:0] m_y;
    always_comb begin
        m_cin = bus.alu_csel ? bus.alu_srcin : bus.alu_ucin;
        m_y   = 16'h0000;
        m_co  = 1'b0;
        if (!bus.alu_notALUOE) begin
            case (bus.alu_f)
                5'b10010: {m_co, m_y} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {16'h0000, m_cin};
                5'b01100: {m_co, m_y} = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + {16'h0000, m_cin};
                5'b10111: m_y = bus.alu_a & bus.alu_b;
                5'b11101: m_y = bus.alu_a | bus.alu_b;
                5'b01101: m_y = bus.alu_a ^ bus.alu_b;
                5'b00001: m_y = ~bus.alu_a;
                5'b11111: m_y = bus.alu_a;
                default:  m_y = 16'h0000;
            endcase
        end else if (!bus.alu_notShiftOE) begin
            case (bus.alu_f[2:0])
                3'b101: begin m_y = {bus.alu_a[14:0], m_cin}; m_co = bus.alu_a[15]; end
                3'b010: begin m_y = {m_cin, bus.alu_a[15:1]}; m_co = bus.alu_a[0]; end
                default: m_y = bus.alu_a;
            endcase
        end
        bus.alu_y    = m_y;
        bus.alu_cout = m_co;
        bus.alu_zout = (m_y == 16'h0000);
    end

    // Bus-rule monitor: never both enables low, both high whenever idle or responding
    always @(negedge clk) begin
        checks++;
        if (!bus.alu_notALUOE && !bus.alu_notShiftOE) begin
            failures++;
            $display("FAIL oe_both_low got notALUOE=0 notShiftOE=0 exp at least one high");
        end
        checks++;
        if ((bus.req_ready || bus.rsp_valid) && !(bus.alu_notALUOE && bus.alu_notShiftOE)) begin
            failures++;
            $display("FAIL oe_idle got notALUOE=%b notShiftOE=%b exp 1 1", bus.alu_notALUOE, bus.alu_notShiftOE);
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Driver: wait idle, present one request, return cycles from accept to rsp_valid
    task automatic run_req(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] cnt, output int lat);
        int guard;
        guard = 0;
        while (!bus.req_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_count = cnt;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (!bus.rsp_valid) begin
            failures++;
            $display("FAIL rsp_timeout op=%h got rsp_valid=0 exp=1 within 100 cycles", op);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin
            failures++;
            $display("FAIL reset_handshake got ready=%b rsp_valid=%b exp 1 0", bus.req_ready, bus.rsp_valid);
        end
        checks++;
        if ({bus.rsp_result, bus.carry_flag, bus.zero_flag} !== 18'h0) begin
            failures++;
            $display("FAIL reset_result got res=%h c=%b z=%b exp 0000 0 0", bus.rsp_result, bus.carry_flag, bus.zero_flag);
        end
        checks++;
        if ({bus.alu_a, bus.alu_b, bus.alu_f, bus.alu_csel, bus.alu_ucin, bus.alu_notALUOE, bus.alu_notShiftOE}
            !== {16'h0000, 16'h0000, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL reset_alu_pins got a=%h b=%h f=%b csel=%b ucin=%b oe=%b%b exp 0 0 0 0 0 11",
                     bus.alu_a, bus.alu_b, bus.alu_f, bus.alu_csel, bus.alu_ucin, bus.alu_notALUOE, bus.alu_notShiftOE);
        end
        checks++;
        if (dbg_state !== ST_IDLE) begin
            failures++;
            $display("FAIL reset_state got %0d exp %0d", dbg_state, ST_IDLE);
        end
    endtask

    task automatic test_arith();
        int lat;
        logic [15:0] vec_a [5] = '{16'hFFFF, 16'h0005, 16'h0001, 16'h0005, 16'h0003};
        logic [15:0] vec_b [5] = '{16'h0001, 16'h0003, 16'h0001, 16'h0003, 16'h0005};
        logic [3:0]  vec_op[5] = '{OP_ADD, OP_SBC, OP_ADC, OP_SBC, OP_SUB};
        // {result, C, Z}: ADD sets C=1, SBC with C=1, ADC with C=1, SBC with C=0, SUB borrow
        logic [17:0] vec_e [5] = '{{16'h0000, 2'b11}, {16'h0002, 2'b10}, {16'h0003, 2'b00},
                                   {16'h0001, 2'b10}, {16'hFFFE, 2'b00}};
        for (int i = 0; i < 5; i++) begin
            run_req(vec_op[i], vec_a[i], vec_b[i], 4'd0, lat);
            checks++;
            if ({bus.rsp_result, bus.carry_flag, bus.zero_flag} !== vec_e[i]) begin
                failures++;
                $display("FAIL arith_%0d op=%h got {res,c,z}=%h exp %h", i, vec_op[i],
                         {bus.rsp_result, bus.carry_flag, bus.zero_flag}, vec_e[i]);
            end
            checks++;
            if (lat !== 2) begin
                failures++;
                $display("FAIL arith_latency_%0d got %0d exp 2", i, lat);
            end
        end
    endtask

    task automatic test_logic();
        int lat;
        logic [15:0] vec_a [5] = '{16'hFFFF, 16'hF0F0, 16'hF0F0, 16'h1234, 16'h00FF};
        logic [15:0] vec_b [5] = '{16'h0001, 16'h0F0F, 16'h0F0F, 16'h1234, 16'h1234};
        logic [3:0]  vec_op[5] = '{OP_ADD, OP_AND, OP_OR, OP_XOR, OP_NOT};
        // ADD first puts C=1; logic ops must leave it alone
        logic [17:0] vec_e [5] = '{{16'h0000, 2'b11}, {16'h0000, 2'b11}, {16'hFFFF, 2'b10},
                                   {16'h0000, 2'b11}, {16'hFF00, 2'b10}};
        for (int i = 0; i < 5; i++) begin
            run_req(vec_op[i], vec_a[i], vec_b[i], 4'd0, lat);
            checks++;
            if ({bus.rsp_result, bus.carry_flag, bus.zero_flag} !== vec_e[i]) begin
                failures++;
                $display("FAIL logic_%0d op=%h got {res,c,z}=%h exp %h", i, vec_op[i],
                         {bus.rsp_result, bus.carry_flag, bus.zero_flag}, vec_e[i]);
            end
        end
    endtask

    task automatic test_cmp();
        int lat;
        logic [15:0] vec_a [3] = '{16'h0003, 16'h1234, 16'h0005};
        logic [15:0] vec_b [3] = '{16'h0005, 16'h1234, 16'h0003};
        logic [3:0]  vec_op[3] = '{OP_SUB, OP_CMP, OP_CMP};
        logic [17:0] vec_e [3] = '{{16'hFFFE, 2'b00}, {16'h0000, 2'b11}, {16'h0000, 2'b10}};
        for (int i = 0; i < 3; i++) begin
            run_req(vec_op[i], vec_a[i], vec_b[i], 4'd0, lat);
            checks++;
            if ({bus.rsp_result, bus.carry_flag, bus.zero_flag} !== vec_e[i]) begin
                failures++;
                $display("FAIL cmp_%0d op=%h got {res,c,z}=%h exp %h", i, vec_op[i],
                         {bus.rsp_result, bus.carry_flag, bus.zero_flag}, vec_e[i]);
            end
        end
    endtask

    task automatic test_shift();
        int lat;
        logic [15:0] vec_a [7] = '{16'h8001, 16'h0001, 16'h8001, 16'hFFFF, 16'h00A5, 16'h0009, 16'h0001};
        logic [3:0]  vec_op[7] = '{OP_SHL, OP_SHR, OP_SHLN, OP_ADD, OP_SHRN, OP_SHRN, OP_SHLN};
        logic [3:0]  vec_n [7] = '{4'd0, 4'd0, 4'd3, 4'd0, 4'd0, 4'd4, 4'd15};
        logic [17:0] vec_e [7] = '{{16'h0002, 2'b10}, {16'h0000, 2'b11}, {16'h0008, 2'b00},
                                   {16'h0000, 2'b11}, {16'h00A5, 2'b10}, {16'h0000, 2'b11},
                                   {16'h8000, 2'b00}};
        int          vec_l [7] = '{2, 2, 4, 2, 2, 5, 16};
        for (int i = 0; i < 7; i++) begin
            run_req(vec_op[i], vec_a[i], 16'h0001, vec_n[i], lat);
            checks++;
            if ({bus.rsp_result, bus.carry_flag, bus.zero_flag} !== vec_e[i]) begin
                failures++;
                $display("FAIL shift_%0d op=%h n=%0d got {res,c,z}=%h exp %h", i, vec_op[i], vec_n[i],
                         {bus.rsp_result, bus.carry_flag, bus.zero_flag}, vec_e[i]);
            end
            checks++;
            if (lat !== vec_l[i]) begin
                failures++;
                $display("FAIL shift_latency_%0d got %0d exp %0d", i, lat, vec_l[i]);
            end
        end
    endtask

    task automatic test_mul();
        int lat;
        logic [15:0] vec_a [4] = '{16'hFFFF, 16'h0123, 16'hFFFF, 16'h1234};
        logic [15:0] vec_b [4] = '{16'h0001, 16'h0045, 16'hFFFF, 16'h0000};
        logic [3:0]  vec_op[4] = '{OP_ADD, OP_MUL, OP_MUL, OP_MUL};
        logic [17:0] vec_e [4] = '{{16'h0000, 2'b11}, {16'h4E6F, 2'b00}, {16'h0001, 2'b00},
                                   {16'h0000, 2'b01}};
        int          vec_l [4] = '{2, 33, 33, 33};
        for (int i = 0; i < 4; i++) begin
            run_req(vec_op[i], vec_a[i], vec_b[i], 4'd0, lat);
            checks++;
            if ({bus.rsp_result, bus.carry_flag, bus.zero_flag} !== vec_e[i]) begin
                failures++;
                $display("FAIL mul_%0d got {res,c,z}=%h exp %h", i,
                         {bus.rsp_result, bus.carry_flag, bus.zero_flag}, vec_e[i]);
            end
            checks++;
            if (lat !== vec_l[i]) begin
                failures++;
                $display("FAIL mul_latency_%0d got %0d exp %0d", i, lat, vec_l[i]);
            end
        end
    endtask

    task automatic test_illegal();
        int lat;
        run_req(OP_ADD, 16'hFFFF, 16'h0001, 4'd0, lat);   // C=1 Z=1
        run_req(OP_OR, 16'hF0F0, 16'h0F0F, 4'd0, lat);    // result FFFF, C=1 Z=0
        run_req(4'hE, 16'h1111, 16'h2222, 4'd0, lat);
        checks++;
        if ({bus.rsp_result, bus.carry_flag, bus.zero_flag, 6'(lat)} !== {16'h0000, 2'b10, 6'd2}) begin
            failures++;
            $display("FAIL illegal_e got res=%h c=%b z=%b lat=%0d exp 0000 1 0 2",
                     bus.rsp_result, bus.carry_flag, bus.zero_flag, lat);
        end
        run_req(4'hF, 16'h0000, 16'h0000, 4'd0, lat);
        checks++;
        if ({bus.rsp_result, bus.carry_flag, bus.zero_flag} !== {16'h0000, 2'b10}) begin
            failures++;
            $display("FAIL illegal_f got res=%h c=%b z=%b exp 0000 1 0",
                     bus.rsp_result, bus.carry_flag, bus.zero_flag);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int busy_ready;
        int guard;
        // 3 * 5, with an ADD request held high through the whole multiply
        guard = 0;
        while (!bus.req_ready && guard < 100) begin @(posedge clk); #1; guard++; end
        bus.req_valid = 1'b1; bus.req_op = OP_MUL; bus.req_a = 16'h0003; bus.req_b = 16'h0005;
        @(posedge clk); #1;
        bus.req_op = OP_ADD; bus.req_a = 16'h0001; bus.req_b = 16'h0001;
        lat = 1; busy_ready = 0;
        while (!bus.rsp_valid && lat < 100) begin
            if (bus.req_ready) busy_ready++;
            @(posedge clk); #1;
            lat++;
        end
        bus.req_valid = 1'b0;
        checks++;
        if (busy_ready !== 0) begin
            failures++;
            $display("FAIL busy_ready got %0d ready cycles exp 0", busy_ready);
        end
        checks++;
        if ({bus.rsp_result, bus.carry_flag, bus.zero_flag, 7'(lat)} !== {16'h000F, 2'b00, 7'd33}) begin
            failures++;
            $display("FAIL busy_result got res=%h c=%b z=%b lat=%0d exp 000f 0 0 33",
                     bus.rsp_result, bus.carry_flag, bus.zero_flag, lat);
        end
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if ({dbg_state, bus.rsp_result} !== {ST_IDLE, 16'h000F}) begin
            failures++;
            $display("FAIL busy_ignored got state=%0d res=%h exp %0d 000f", dbg_state, bus.rsp_result, ST_IDLE);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        run_req(OP_ADD, 16'hFFFF, 16'h0002, 4'd0, lat);
        checks++;
        if ({bus.rsp_result, bus.carry_flag, bus.zero_flag} !== {16'h0001, 2'b10}) begin
            failures++;
            $display("FAIL pre_reset got {res,c,z}=%h exp %h", {bus.rsp_result, bus.carry_flag, bus.zero_flag},
                     {16'h0001, 2'b10});
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_op = OP_MUL; bus.req_a = 16'h0123; bus.req_b = 16'h0045;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.carry_flag, bus.zero_flag}
            !== {1'b1, 1'b0, 16'h0000, 2'b00}) begin
            failures++;
            $display("FAIL mid_reset got ready=%b rsp_valid=%b res=%h c=%b z=%b exp 1 0 0000 0 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.carry_flag, bus.zero_flag);
        end
        seen = 0;
        repeat (40) begin
            if (bus.rsp_valid) seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL mid_reset_no_rsp got %0d rsp_valid cycles exp 0", seen);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 4'h0;
        bus.req_a     = 16'h0000;
        bus.req_b     = 16'h0000;
        bus.req_count = 4'd0;
        test_reset();
        test_arith();
        test_logic();
        test_cmp();
        test_shift();
        test_mul();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
